dac_ramp_ctrl: RTL and testbench
================================

// Module: dac_ramp_ctrl
// PURPOSE
//   Sequences the R2R DAC code of the adjustable PSU. Accepts a target setpoint over a
//   valid/ready handshake and slews dac_code toward it in bounded steps at a prescaled
//   rate, giving a soft-start / soft-change of output voltage. Sits between setpoint
//   logic and the DAC pins; the only driver of the DAC code.
// PARAMETERS
//   WIDTH     4     DAC code width in bits
//   PRESCALE  1000  clk cycles per ramp step (10 MHz clk -> 10 kHz step rate); >= 1
//   STEP      1     max code change per ramp step; 1 <= STEP <= 2**WIDTH-1
// PORTS
//   clk        in   1      system clock, 10 MHz
//   n_reset    in   1      asynchronous, active-low reset
//   set_valid  in   1      setpoint request valid
//   set_ready  out  1      controller can accept a setpoint
//   set_code   in   WIDTH  requested target DAC code
//   abort      in   1      stop an active ramp, hold present code
//   dac_code   out  WIDTH  registered code to the R2R DAC
//   busy       out  1      ramp in progress
//   done       out  1      one-cycle pulse: target reached
//   at_target  out  1      dac_code == latched target
// BEHAVIOUR
//   Reset (n_reset low, async): dac_code=0, target=0, state IDLE, prescaler=0,
//     set_ready=1, busy=0, done=0, at_target=1. Deassertion: no extra sync stage.
//   All outputs registered except set_ready = (state==IDLE), busy = (state==RAMP),
//     at_target = (dac_code==target).
//   States: IDLE, RAMP.
//   IDLE: accept on edge where set_valid & set_ready; target <= set_code.
//     - set_code == dac_code: stay IDLE; done=1 for the next cycle.
//     - else: -> RAMP; prescaler <= 0.
//     - abort in IDLE ignored (including same cycle as an accepted request).
//   RAMP: set_ready=0; set_valid is not accepted and may be held by the requester.
//     - prescaler counts 0..PRESCALE-1, then wraps to 0; wrap cycle is a step tick.
//     - On tick: diff = target - dac_code at WIDTH+1 bits signed;
//       dac_code moves toward target by min(STEP, |diff|). No overshoot, no wrap.
//     - If the updated dac_code equals target: -> IDLE, done=1 for one cycle,
//       coincident with the final dac_code value.
//     - First code change occurs PRESCALE cycles after the accept edge;
//       total ramp = ceil(|diff|/STEP) * PRESCALE cycles.
//     - abort=1: -> IDLE on next edge; dac_code holds its value (any tick that same
//       cycle is discarded); target <= dac_code; done not pulsed.
//   PRESCALE=1: one step per clock in RAMP.
//   Reset mid-ramp: immediate return to reset values; the pending target is lost.
//   done is never asserted while busy=1 in the same cycle after the final step
//     transition (done and busy are mutually exclusive).
// TESTING
//   1. PRESCALE=4, STEP=1: request 9 from 0 -> dac_code 1..9, one step every 4 clk;
//      done pulses once, 36 clk after accept; busy low afterwards.
//   2. STEP=4, from 15 request 2 -> sequence 15,11,7,3,2 (last step clamped); done pulses
//      once; never below 2.
//   3. At dac_code=5 request 5 -> busy stays 0, done pulses next cycle, dac_code=5.
//   4. Ramp 0->12, abort when dac_code=6 -> dac_code holds 6, busy=0, no done,
//      at_target=1; a new request is accepted in the following cycle.
//   5. Hold set_valid=1 with code 3 during a ramp to 10 -> set_ready=0, no accept until IDLE;
//      then accepts 3 and ramps down.
//   6. Pull n_reset low mid-ramp, between edges -> dac_code=0, busy=0, set_ready=1,
//      asynchronously before the next clk edge.

Source files
------------

// File: rtl/dac_ramp_ctrl.sv
// DAC code slew controller: accepts a target setpoint over valid/ready and walks
// dac_code toward it by at most STEP codes every PRESCALE clocks.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | holding dac_code, ready for a new setpoint
//   RAMP  | stepping dac_code toward target on each prescaler wrap
module dac_ramp_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1000,
    parameter int STEP     = 1
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             set_valid,
    output logic             set_ready,
    input  logic [WIDTH-1:0] set_code,
    input  logic             abort,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic             at_target
);

    localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH:0]  STEP_W   = (WIDTH + 1)'(STEP);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_dac_code, w_dac_code_nxt;
    logic [WIDTH-1:0] r_target, w_target_nxt;
    logic [PW-1:0]    r_prescale, w_prescale_nxt;
    logic             r_done, w_done_nxt;

    logic             w_tick;
    logic [WIDTH:0]   w_diff;
    logic             w_neg;
    logic [WIDTH:0]   w_mag;
    logic [WIDTH:0]   w_step;
    logic [WIDTH-1:0] w_stepped;
    logic             w_reach;

    // Signed distance to target at WIDTH+1 bits; the step is clamped to it so the
    // code can never overshoot or wrap.
    assign w_tick    = (r_prescale == PRE_LAST);
    assign w_diff    = {1'b0, r_target} - {1'b0, r_dac_code};
    assign w_neg     = w_diff[WIDTH];
    assign w_mag     = w_neg ? (~w_diff + (WIDTH + 1)'(1)) : w_diff;
    assign w_step    = (w_mag > STEP_W) ? STEP_W : w_mag;
    assign w_reach   = (w_step == w_mag);
    assign w_stepped = w_neg ? (r_dac_code - w_step[WIDTH-1:0])
                             : (r_dac_code + w_step[WIDTH-1:0]);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state    <= IDLE;
            r_dac_code <= '0;
            r_target   <= '0;
            r_prescale <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dac_code <= w_dac_code_nxt;
            r_target   <= w_target_nxt;
            r_prescale <= w_prescale_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_dac_code_nxt = r_dac_code;
        w_target_nxt   = r_target;
        w_prescale_nxt = r_prescale;
        w_done_nxt     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (set_valid) begin
                    w_target_nxt = set_code;
                    if (set_code == r_dac_code) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt    = RAMP;
                        w_prescale_nxt = '0;
                    end
                end
            end
            RAMP: begin
                // Abort wins over a coincident tick: the code freezes where it is.
                if (abort) begin
                    w_state_nxt    = IDLE;
                    w_target_nxt   = r_dac_code;
                    w_prescale_nxt = '0;
                end else if (w_tick) begin
                    w_prescale_nxt = '0;
                    w_dac_code_nxt = w_stepped;
                    if (w_reach) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_prescale_nxt = r_prescale + PW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign set_ready = (r_state == IDLE);
    assign busy      = (r_state == RAMP);
    assign at_target = (r_dac_code == r_target);
    assign dac_code  = r_dac_code;
    assign done      = r_done;

endmodule

// File: tb/tb_dac_ramp_ctrl.sv
// Bench for dac_ramp_ctrl: closed-form ramp model at posedge, monitor at negedge
// compares outputs every cycle and pops expected done pulses from a queue.
module tb_dac_ramp_ctrl;

    localparam int W = 4;
    localparam int P = 4;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         n_reset = 1'b0;
    logic         set_valid = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] set_code = '0;
    logic         set_ready, busy, done, at_target;
    logic [W-1:0] dac_code;

    int tests = 0;
    int fails = 0;

    dac_ramp_ctrl #(.WIDTH(W), .PRESCALE(P), .STEP(S)) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .set_valid(set_valid),
        .set_ready(set_ready),
        .set_code (set_code),
        .abort    (abort),
        .dac_code (dac_code),
        .busy     (busy),
        .done     (done),
        .at_target(at_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: position along a ramp is start + dir*min(k*STEP, dist),
    // with k = whole prescale periods elapsed since the accept edge.
    logic [W-1:0] m_code = '0;
    logic [W-1:0] m_target = '0;
    bit           m_busy = 1'b0;
    int           m_start = 0, m_dist = 0, m_dir = 0, m_el = 0, m_mv = 0;
    int           mon_cyc = 0;
    int           done_q[$];
    int           done_code_q[$];

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            m_code = '0;
            m_target = '0;
            m_busy = 1'b0;
            done_q.delete();
            done_code_q.delete();
        end else if (!m_busy) begin
            if (set_valid) begin
                m_target = set_code;
                if (set_code == m_code) begin
                    done_q.push_back(mon_cyc + 1);
                    done_code_q.push_back(int'(m_code));
                end else begin
                    m_busy  = 1'b1;
                    m_start = int'(m_code);
                    m_el    = 0;
                    m_dir   = (set_code > m_code) ? 1 : -1;
                    m_dist  = (set_code > m_code) ? int'(set_code) - int'(m_code)
                                                  : int'(m_code) - int'(set_code);
                end
            end
        end else if (abort) begin
            m_busy = 1'b0;
            m_target = m_code;
        end else begin
            m_el++;
            m_mv = (m_el / P) * S;
            if (m_mv > m_dist) m_mv = m_dist;
            m_code = W'(m_start + m_dir * m_mv);
            if (m_mv == m_dist) begin
                m_busy = 1'b0;
                done_q.push_back(mon_cyc + 1);
                done_code_q.push_back(int'(m_code));
            end
        end
    end

    always @(negedge clk) begin
        mon_cyc++;
        check("dac_code", dac_code, m_code);
        check("busy", busy, m_busy);
        check("set_ready", set_ready, !m_busy);
        check("at_target", at_target, (m_code == m_target));
        if (done_q.size() > 0 && done_q[0] == mon_cyc) begin
            check("done_pulse", done, 1);
            check("done_code", dac_code, done_code_q[0]);
            void'(done_q.pop_front());
            void'(done_code_q.pop_front());
        end else if (done) begin
            check("done_spurious", done, 0);
        end
    end

    // All stimulus tasks start and end aligned to a negedge.
    task automatic req(input logic [W-1:0] c);
        bit acc = 1'b0;
        set_valid = 1'b1;
        set_code  = c;
        for (int n = 0; n < 200; n++) begin
            if (!m_busy) acc = 1'b1;
            @(negedge clk);
            if (acc) break;
        end
        set_valid = 1'b0;
        check("accept_timeout", acc, 1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200; n++) begin
            if (!m_busy) break;
            @(negedge clk);
        end
        check("idle_timeout", m_busy, 0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int c, mode, wait_n;
        repeat (2) @(negedge clk);
        check("rst_dac_code", dac_code, 0);
        check("rst_set_ready", set_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_at_target", at_target, 1);
        n_reset = 1'b1;
        @(negedge clk);

        req(4'd9);  wait_idle(); cycles(2);
        req(4'd15); wait_idle();
        req(4'd2);  wait_idle();
        req(4'd2);  cycles(3);
        req(4'd0);  wait_idle();

        req(4'd12);
        for (int n = 0; n < 100 && m_code != 4'd6; n++) @(negedge clk);
        check("abort_reached6", m_code, 6);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_hold", dac_code, 6);
        check("abort_busy", busy, 0);
        check("abort_at_target", at_target, 1);
        req(4'd4); wait_idle();

        req(4'd10);
        check("hold_ready_low", set_ready, 0);
        req(4'd3); wait_idle();

        abort = 1'b1;
        req(4'd7);
        abort = 1'b0;
        wait_idle();

        req(4'd14);
        cycles(5);
        @(posedge clk);
        #2 n_reset = 1'b0;
        #1;
        check("async_rst_code", dac_code, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_ready", set_ready, 1);
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            c      = $urandom_range(0, 15);
            mode   = $urandom_range(0, 2);
            wait_n = $urandom_range(0, 12);
            req(W'(c));
            case (mode)
                0: wait_idle();
                1: begin
                    cycles(wait_n);
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                end
                default: cycles(wait_n);
            endcase
        end

        wait_idle();
        cycles(3);
        check("done_pending", done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
